calc_exec_seq: RTL and testbench

- Sequencer that runs one arithmetic operation of the keypad calculator on packed-BCD operands from the input controller.
- Flow per operation: BCD->binary conversion, add/sub (1 step) or iterative shift-add multiply / restoring divide, then binary->BCD (double dabble).
- Returns the BCD result with status flags and a one-cycle done pulse. The input controller loads the result back into its first-operand register.

---
 rtl/calc_exec_seq.sv | 167 ++++++++++++++++
 tb/tb_calc_exec_seq.sv | 98 +++++++++
 2 files changed

// File: rtl/calc_exec_seq.sv
// calc_exec_seq: runs one BCD calculator operation (BCD->bin, add/sub/mul/div, bin->BCD).
// Define CALC_REM_EN to convert and drive the division remainder on rem.
module calc_exec_seq #(
    parameter int DIGITS = 6,
    parameter int BIN_W  = 20
) (
    input  logic                CLK_1K,
    input  logic                RST,
    input  logic                start,
    input  logic [3:0]          opcode,
    input  logic [4*DIGITS-1:0] opa,
    input  logic [4*DIGITS-1:0] opb,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] result,
    output logic                neg,
    output logic                ovf,
    output logic                err,
    output logic [4*DIGITS-1:0] rem
);
    localparam int BW = 4*DIGITS;
    localparam int CW = $clog2(BIN_W+1);
    localparam logic [BIN_W:0]     MAXS = (BIN_W+1)'(10**DIGITS-1);
    localparam logic [2*BIN_W-1:0] MAXP = (2*BIN_W)'(10**DIGITS-1);
    localparam logic [3:0] OP_ADD = 4'ha, OP_SUB = 4'hb, OP_MUL = 4'hc, OP_DIV = 4'hd;

    typedef enum logic [2:0] {IDLE, CONV, EXEC, BACK, DONE} state_t;
    state_t state, nstate;

    logic [CW-1:0]      cnt;
    logic [3:0]         op;
    logic [BW-1:0]      qa, qb, bcd, bcd_n;
    logic [BIN_W-1:0]   a, b, a_n, b_n, sh, ev, diff;
    logic [BIN_W:0]     sum, rs, rd;
    logic [2*BIN_W-1:0] p, p_n, p_mul, p_div;
    logic [3:0]         da, db;
    logic               bad, op_ok, conv_last, conv_err, exec_last, exec_ovf, back_last, ge;
    logic               neg_i, err_i, busy_n, done_n;

    // one double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit
    function automatic logic [BW-1:0] dd(input logic [BW-1:0] v, input logic s);
        logic [BW-1:0] t;
        for (int i = 0; i < DIGITS; i++)
            t[4*i +: 4] = v[4*i +: 4] >= 4'd5 ? v[4*i +: 4] + 4'd3 : v[4*i +: 4];
        return {t[BW-2:0], s};
    endfunction

    always_comb begin
        da        = qa[BW-1 -: 4];
        db        = qb[BW-1 -: 4];
        a_n       = a * BIN_W'(10) + BIN_W'(da);
        b_n       = b * BIN_W'(10) + BIN_W'(db);
        bad       = (da > 4'd9) || (db > 4'd9);
        op_ok     = (op >= OP_ADD) && (op <= OP_DIV);
        conv_last = (state == CONV) && (cnt == CW'(DIGITS-1));
        conv_err  = err_i || bad || !op_ok || ((op == OP_DIV) && (b_n == '0));
        sum       = {1'b0, a} + {1'b0, b};
        diff      = a >= b ? a - b : b - a;
        p_mul     = {{1'b0, p[2*BIN_W-1:BIN_W]} + (p[0] ? {1'b0, a} : '0), p[BIN_W-1:1]};
        rs        = {p[2*BIN_W-1:BIN_W], p[BIN_W-1]};
        rd        = rs - {1'b0, b};
        ge        = rs >= {1'b0, b};
        p_div     = {ge ? rd[BIN_W-1:0] : rs[BIN_W-1:0], p[BIN_W-2:0], ge};
        p_n       = op == OP_MUL ? p_mul : p_div;
        exec_last = (state == EXEC) && (op == OP_ADD || op == OP_SUB || cnt == CW'(BIN_W-1));
        exec_ovf  = op == OP_ADD ? sum > MAXS : (op == OP_MUL) && (p_n > MAXP);
        ev        = op == OP_ADD ? sum[BIN_W-1:0] : op == OP_SUB ? diff : p_n[BIN_W-1:0];
        back_last = (state == BACK) && (cnt == CW'(BIN_W-1));
        bcd_n     = dd(bcd, sh[BIN_W-1]);
    end

    always_ff @(posedge CLK_1K or negedge RST)
        if (!RST) state <= IDLE;
        else      state <= nstate;

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    nstate = start ? CONV : IDLE;
            CONV:    nstate = conv_last ? (conv_err ? DONE : EXEC) : CONV;
            EXEC:    nstate = exec_last ? (exec_ovf ? DONE : BACK) : EXEC;
            BACK:    nstate = back_last ? DONE : BACK;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        busy_n = (nstate != IDLE) && (nstate != DONE);
        done_n = nstate == DONE;
    end

    always_ff @(posedge CLK_1K or negedge RST) begin
        if (!RST) begin
            {busy, done, neg, ovf, err, neg_i, err_i} <= '0;
            {cnt, op, qa, qb, a, b, p, sh, bcd, result} <= '0;
        end else begin
            busy <= busy_n;
            done <= done_n;
            cnt  <= nstate != state ? '0 : cnt + 1'b1;
            case (state)
                IDLE: if (start) begin
                    {op, qa, qb} <= {opcode, opa, opb};
                    {a, b, neg_i, err_i, neg, ovf, err} <= '0;
                end
                CONV: begin
                    qa    <= qa << 4;
                    qb    <= qb << 4;
                    a     <= a_n;
                    b     <= b_n;
                    err_i <= err_i | bad;
                    // the multiplier or dividend sits in the low half of p
                    if (conv_last) p <= {{BIN_W{1'b0}}, op == OP_DIV ? a_n : b_n};
                    if (conv_last && conv_err) begin
                        result <= '0;
                        err    <= 1'b1;
                    end
                end
                EXEC: begin
                    p <= p_n;
                    if (exec_last) begin
                        sh    <= ev;
                        bcd   <= '0;
                        neg_i <= (op == OP_SUB) && (a < b);
                    end
                    if (exec_last && exec_ovf) begin
                        ovf    <= 1'b1;
                        result <= {DIGITS{4'h9}};
                    end
                end
                BACK: begin
                    bcd <= bcd_n;
                    sh  <= sh << 1;
                    if (back_last) begin
                        result <= bcd_n;
                        neg    <= neg_i;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CALC_REM_EN
    logic [BIN_W-1:0] rsh;
    logic [BW-1:0]    rbcd, rbcd_n;
    assign rbcd_n = dd(rbcd, rsh[BIN_W-1]);

    always_ff @(posedge CLK_1K or negedge RST) begin
        if (!RST) begin
            {rsh, rbcd, rem} <= '0;
        end else begin
            if (state == IDLE && start) rem <= '0;
            if (exec_last) begin
                rsh  <= op == OP_DIV ? p_n[2*BIN_W-1:BIN_W] : '0;
                rbcd <= '0;
            end
            if (state == BACK) begin
                rbcd <= rbcd_n;
                rsh  <= rsh << 1;
            end
            if (back_last) rem <= rbcd_n;
        end
    end
`else
    assign rem = '0;
`endif
endmodule

// File: tb/tb_calc_exec_seq.sv
// tb_calc_exec_seq: directed vectors with hand-computed results and latencies.
module tb_calc_exec_seq;
    logic        CLK_1K = 1'b0, RST = 1'b0, start = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic [23:0] opa = '0, opb = '0, result, rem;
    logic        busy, done, neg, ovf, err;
    int          n_run = 0, n_fail = 0;

    calc_exec_seq dut (
        .CLK_1K(CLK_1K), .RST(RST), .start(start), .opcode(opcode), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .result(result), .neg(neg), .ovf(ovf), .err(err), .rem(rem)
    );

    always #5 CLK_1K = ~CLK_1K;

`ifdef CALC_REM_EN
    localparam logic [23:0] DIV_REM = 24'h000002;
`else
    localparam logic [23:0] DIV_REM = 24'h000000;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic go(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b);
        repeat (2) @(negedge CLK_1K);
        {opcode, opa, opb, start} = {op, a, b, 1'b1};
        @(posedge CLK_1K);
        #1 start = 1'b0;
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [23:0] a,
                       input logic [23:0] b, input int lat, input logic [23:0] res,
                       input logic n, input logic o, input logic e, input logic [23:0] r);
        int c = 1;
        go(op, a, b);
        chk({tag, " busy"}, busy, 1'b1);
        while (!done && c < 100) begin
            @(posedge CLK_1K);
            #1 c++;
        end
        chk({tag, " latency"}, c, lat);
        chk({tag, " result"}, result, res);
        chk({tag, " flags"}, {neg, ovf, err, busy}, {n, o, e, 1'b0});
        chk({tag, " rem"}, rem, r);
    endtask

    initial begin
        int dn;
        #12;
        chk("reset outs", {busy, done, neg, ovf, err, result, rem}, '0);
        @(negedge CLK_1K) RST = 1'b1;

        go(4'hc, 24'h000123, 24'h000045);
        repeat (19) @(posedge CLK_1K);
        #1 RST = 1'b0;
        #1 chk("midreset outs", {busy, done, neg, ovf, err, result, rem}, '0);
        @(negedge CLK_1K) RST = 1'b1;
        dn = 0;
        repeat (60) begin
            @(posedge CLK_1K);
            #1 dn += int'(done);
        end
        chk("midreset no done", dn, 0);

        run("add",      4'ha, 24'h000123, 24'h000877, 28, 24'h001000, 0, 0, 0, 0);
        run("sub neg",  4'hb, 24'h000005, 24'h000012, 28, 24'h000007, 1, 0, 0, 0);
        run("sub pos",  4'hb, 24'h000012, 24'h000005, 28, 24'h000007, 0, 0, 0, 0);
        run("mul",      4'hc, 24'h000999, 24'h000999, 47, 24'h998001, 0, 0, 0, 0);
        run("mul ovf",  4'hc, 24'h001000, 24'h001000, 27, 24'h999999, 0, 1, 0, 0);
        run("div",      4'hd, 24'h000100, 24'h000007, 47, 24'h000014, 0, 0, 0, DIV_REM);
        run("div zero", 4'hd, 24'h000100, 24'h000000, 7,  24'h000000, 0, 0, 1, 0);
        run("bad op",   4'he, 24'h000001, 24'h000002, 7,  24'h000000, 0, 0, 1, 0);
        run("bad bcd",  4'ha, 24'h00000f, 24'h000001, 7,  24'h000000, 0, 0, 1, 0);
        run("add ovf",  4'ha, 24'h999999, 24'h999999, 8,  24'h999999, 0, 1, 0, 0);
        run("mul max",  4'hc, 24'h999999, 24'h000001, 47, 24'h999999, 0, 0, 0, 0);

        go(4'ha, 24'h000040, 24'h000002);
        dn = 0;
        for (int i = 0; i < 60; i++) begin
            start = (i % 7 == 3);
            opcode = 4'hc;
            @(posedge CLK_1K);
            #1 dn += int'(done);
        end
        start = 1'b0;
        chk("busy start ignored", dn, 1);
        chk("busy start result", result, 24'h000042);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
